// File: rtl/fiber_access_pkg.sv
// Shared token constants, token decoding and read-FSM encoding for fiber_access.
package fiber_access_pkg;

    localparam logic [16:0] DONE_TOKEN = 17'h10100;
    localparam logic [16:0] STOP_BASE  = 17'h10000;

    typedef enum logic [1:0] {
        TOK_DATA = 2'd0,
        TOK_STOP = 2'd1,
        TOK_DONE = 2'd2,
        TOK_NONE = 2'd3
    } tok_kind_e;

    typedef enum logic [2:0] {
        RD_IDLE     = 3'd0,
        RD_LEN      = 3'd1,
        RD_RD       = 3'd2,
        RD_WAIT     = 3'd3,
        RD_EMIT     = 3'd4,
        RD_DONE_OUT = 3'd5
    } rd_state_e;

    // Unrecognised control tokens are accepted and dropped.
    function automatic tok_kind_e decode_token(input logic [16:0] tok);
        if (!tok[16])                           return TOK_DATA;
        if (tok == DONE_TOKEN)                  return TOK_DONE;
        if (tok[16:8] == STOP_BASE[16:8])       return TOK_STOP;
        return TOK_NONE;
    endfunction

endpackage

// File: rtl/fiber_access_len.sv
// fiber_len_fifo: small FIFO of completed-fiber descriptors {done_marker, length}.
module fiber_len_fifo #(
    parameter int unsigned W     = 17,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rp_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        if (do_push) wp_d = (wp_q == AW'(DEPTH-1)) ? '0 : wp_q + 1'b1;
        if (do_pop)  rp_d = (rp_q == AW'(DEPTH-1)) ? '0 : rp_q + 1'b1;
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else if (en_i) begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (en_i && !flush_i && do_push) mem_q[wp_q] <= data_i;
    end

endmodule

// File: rtl/fiber_access.sv
// Sparse fiber buffer: packs a coordinate stream into SRAM, replays fibers as length+coords blocks.
// Optional cycle counters are built when FIBER_ACCESS_PERF_EN is defined.
module fiber_access
    import fiber_access_pkg::*;
#(
    parameter int unsigned DW        = 16,
    parameter int unsigned MEM_AW    = 9,
    parameter int unsigned LEN_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic              flush,
    input  logic              tile_en,
    input  logic [3:0]        buffet_capacity_log,
    input  logic [DW:0]       wr_data_in,
    input  logic              wr_data_in_valid,
    output logic              wr_data_in_ready,
    output logic [DW:0]       blk_out,
    output logic              blk_out_valid,
    input  logic              blk_out_ready,
    output logic [MEM_AW-1:0] addr_to_mem,
    output logic [4*DW-1:0]   data_to_mem,
    output logic              wen_to_mem,
    output logic              ren_to_mem,
    input  logic [4*DW-1:0]   data_from_mem
`ifdef FIBER_ACCESS_PERF_EN
    ,
    output logic [31:0]       perf_wr_cycles,
    output logic [31:0]       perf_rd_cycles
`endif
);
    localparam int unsigned LW  = 4 * DW;
    localparam int unsigned CW  = MEM_AW + 1;
    localparam int unsigned FLW = MEM_AW + 3;

    logic [3:0]        cap_log;
    logic [CW-1:0]     capacity;
    logic [MEM_AW-1:0] addr_mask;
    logic              en, full, wr_hs, rd_hs, rd_free;
    tok_kind_e         kind;

    logic [LW-1:0]     line_q, line_d, line_ins, pend_data_q, pend_data_d, rd_line_q, rd_line_d;
    logic [1:0]        lane_q, lane_d, rd_lane_q, rd_lane_d;
    logic [FLW-1:0]    fib_len_q, fib_len_d;
    logic [MEM_AW-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_nx, pend_addr_q, pend_addr_d;
    logic [MEM_AW-1:0] rd_ptr_q, rd_ptr_d, rd_ptr_nx;
    logic              pend_q, pend_d;
    logic [CW-1:0]     words_used_q, words_used_d, free_words;
    logic [DW-1:0]     rd_len_q, rd_len_d, rem_q, rem_d, len_p3;
    rd_state_e         state_q, state_d;

    logic              len_push, len_full, len_empty;
    logic [DW:0]       len_din, len_dout;

    assign cap_log   = (buffet_capacity_log > 4'(MEM_AW)) ? 4'(MEM_AW) : buffet_capacity_log;
    assign capacity  = CW'(1) << cap_log;
    assign addr_mask = MEM_AW'(capacity - 1'b1);
    assign en        = clk_en & tile_en;

    assign wen_to_mem    = en & pend_q;
    assign ren_to_mem    = en & (state_q == RD_RD) & ~pend_q;
    assign addr_to_mem   = wen_to_mem ? pend_addr_q : (ren_to_mem ? rd_ptr_q : '0);
    assign data_to_mem   = wen_to_mem ? pend_data_q : '0;

    // The pending (not yet committed) word already reserves its slot.
    assign full             = (words_used_q + CW'(pend_q)) >= capacity;
    assign wr_data_in_ready = en & ~full & ~len_full;
    assign wr_hs            = wr_data_in_valid & wr_data_in_ready;
    assign kind             = decode_token(wr_data_in);

    assign wr_ptr_nx = (wr_ptr_q + 1'b1) & addr_mask;
    assign rd_ptr_nx = (rd_ptr_q + 1'b1) & addr_mask;

    always_comb begin
        line_ins = line_q;
        line_ins[32'(lane_q)*DW +: DW] = wr_data_in[DW-1:0];
    end

    always_comb begin
        line_d      = line_q;
        lane_d      = lane_q;
        fib_len_d   = fib_len_q;
        wr_ptr_d    = wr_ptr_q;
        pend_d      = pend_q & ~wen_to_mem;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        len_push    = 1'b0;
        len_din     = '0;
        if (wr_hs) begin
            unique case (kind)
                TOK_DATA: begin
                    fib_len_d = fib_len_q + 1'b1;
                    lane_d    = lane_q + 1'b1;
                    line_d    = line_ins;
                    if (lane_q == 2'd3) begin
                        pend_d      = 1'b1;
                        pend_addr_d = wr_ptr_q;
                        pend_data_d = line_ins;
                        line_d      = '0;
                        wr_ptr_d    = wr_ptr_nx;
                    end
                end
                TOK_STOP: begin
                    if (lane_q != 2'd0) begin
                        pend_d      = 1'b1;
                        pend_addr_d = wr_ptr_q;
                        pend_data_d = line_q;
                        wr_ptr_d    = wr_ptr_nx;
                    end
                    line_d    = '0;
                    lane_d    = '0;
                    fib_len_d = '0;
                    len_push  = 1'b1;
                    len_din   = {1'b0, DW'(fib_len_q)};
                end
                TOK_DONE: begin
                    len_push = 1'b1;
                    len_din  = {1'b1, {DW{1'b0}}};
                end
                default: ;
            endcase
        end
    end

    assign blk_out_valid = en & ((state_q == RD_LEN) | (state_q == RD_EMIT) | (state_q == RD_DONE_OUT));
    assign rd_hs         = blk_out_valid & blk_out_ready;

    always_comb begin
        unique case (state_q)
            RD_LEN:      blk_out = {1'b0, rd_len_q};
            RD_EMIT:     blk_out = {1'b0, rd_line_q[32'(rd_lane_q)*DW +: DW]};
            RD_DONE_OUT: blk_out = DONE_TOKEN;
            default:     blk_out = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        rd_len_d  = rd_len_q;
        rem_d     = rem_q;
        rd_lane_d = rd_lane_q;
        rd_line_d = rd_line_q;
        rd_free   = 1'b0;
        unique case (state_q)
            RD_IDLE: if (!len_empty) begin
                rd_len_d = len_dout[DW-1:0];
                state_d  = len_dout[DW] ? RD_DONE_OUT : RD_LEN;
            end
            RD_LEN: if (rd_hs) begin
                rem_d     = rd_len_q;
                rd_lane_d = '0;
                state_d   = (rd_len_q != '0) ? RD_RD : RD_IDLE;
            end
            RD_RD: if (ren_to_mem) state_d = RD_WAIT;
            RD_WAIT: begin
                rd_line_d = data_from_mem;
                state_d   = RD_EMIT;
            end
            RD_EMIT: if (rd_hs) begin
                rem_d     = rem_q - 1'b1;
                rd_lane_d = rd_lane_q + 1'b1;
                if (rem_q == DW'(1)) begin
                    rd_free  = 1'b1;
                    rd_ptr_d = rd_ptr_nx;
                    state_d  = RD_IDLE;
                end else if (rd_lane_q == 2'd3) begin
                    rd_ptr_d = rd_ptr_nx;
                    state_d  = RD_RD;
                end
            end
            RD_DONE_OUT: if (rd_hs) state_d = RD_IDLE;
            default: state_d = RD_IDLE;
        endcase
    end

    assign len_p3       = rd_len_q + DW'(3);
    assign free_words   = CW'(len_p3 >> 2);
    assign words_used_d = words_used_q + CW'(wen_to_mem) - (rd_free ? free_words : '0);

    fiber_len_fifo #(.W(DW + 1), .DEPTH(LEN_DEPTH)) u_len_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .en_i    (clk_en),
        .flush_i (flush),
        .push_i  (len_push),
        .data_i  (len_din),
        .pop_i   (state_q == RD_IDLE),
        .data_o  (len_dout),
        .full_o  (len_full),
        .empty_o (len_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q <= '0; lane_q <= '0; fib_len_q <= '0; wr_ptr_q <= '0;
            pend_q <= 1'b0; pend_addr_q <= '0; pend_data_q <= '0; words_used_q <= '0;
            state_q <= RD_IDLE; rd_ptr_q <= '0; rd_len_q <= '0; rem_q <= '0;
            rd_lane_q <= '0; rd_line_q <= '0;
        end else if (flush) begin
            line_q <= '0; lane_q <= '0; fib_len_q <= '0; wr_ptr_q <= '0;
            pend_q <= 1'b0; pend_addr_q <= '0; pend_data_q <= '0; words_used_q <= '0;
            state_q <= RD_IDLE; rd_ptr_q <= '0; rd_len_q <= '0; rem_q <= '0;
            rd_lane_q <= '0; rd_line_q <= '0;
        end else if (clk_en) begin
            line_q <= line_d; lane_q <= lane_d; fib_len_q <= fib_len_d; wr_ptr_q <= wr_ptr_d;
            pend_q <= pend_d; pend_addr_q <= pend_addr_d; pend_data_q <= pend_data_d;
            words_used_q <= words_used_d;
            state_q <= state_d; rd_ptr_q <= rd_ptr_d; rd_len_q <= rd_len_d; rem_q <= rem_d;
            rd_lane_q <= rd_lane_d; rd_line_q <= rd_line_d;
        end
    end

`ifdef FIBER_ACCESS_PERF_EN
    logic        wr_act_q, rd_act_q, wr_run, rd_run;
    logic [31:0] wr_cyc_q, rd_cyc_q;

    assign wr_run = wr_act_q | wr_hs;
    assign rd_run = rd_act_q | blk_out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_act_q <= 1'b0; rd_act_q <= 1'b0; wr_cyc_q <= '0; rd_cyc_q <= '0;
        end else if (flush) begin
            wr_act_q <= 1'b0; rd_act_q <= 1'b0; wr_cyc_q <= '0; rd_cyc_q <= '0;
        end else if (clk_en) begin
            wr_act_q <= wr_run & ~(wr_hs & (kind == TOK_DONE));
            rd_act_q <= rd_run & ~(rd_hs & (state_q == RD_DONE_OUT));
            if (wr_run && wr_cyc_q != '1) wr_cyc_q <= wr_cyc_q + 1'b1;
            if (rd_run && rd_cyc_q != '1) rd_cyc_q <= rd_cyc_q + 1'b1;
        end
    end

    assign perf_wr_cycles = wr_cyc_q;
    assign perf_rd_cycles = rd_cyc_q;
`endif

endmodule

// File: tb/tb_fiber_access.sv
// Scoreboard bench for fiber_access with a behavioural single-port SRAM.
module tb_fiber_access;
    import fiber_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, clk_en = 1'b1, flush = 1'b0, tile_en = 1'b0;
    logic [3:0]  buffet_capacity_log = 4'd9;
    logic [16:0] wr_data_in = '0;
    logic        wr_data_in_valid = 1'b0, wr_data_in_ready;
    logic [16:0] blk_out;
    logic        blk_out_valid, blk_out_ready = 1'b0;
    logic [8:0]  addr_to_mem;
    logic [63:0] data_to_mem, data_from_mem;
    logic        wen_to_mem, ren_to_mem;

    always #5 clk = ~clk;

    fiber_access #(.DW(16), .MEM_AW(9), .LEN_DEPTH(4)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .clk_en              (clk_en),
        .flush               (flush),
        .tile_en             (tile_en),
        .buffet_capacity_log (buffet_capacity_log),
        .wr_data_in          (wr_data_in),
        .wr_data_in_valid    (wr_data_in_valid),
        .wr_data_in_ready    (wr_data_in_ready),
        .blk_out             (blk_out),
        .blk_out_valid       (blk_out_valid),
        .blk_out_ready       (blk_out_ready),
        .addr_to_mem         (addr_to_mem),
        .data_to_mem         (data_to_mem),
        .wen_to_mem          (wen_to_mem),
        .ren_to_mem          (ren_to_mem),
        .data_from_mem       (data_from_mem)
    );

    logic [63:0] mem [512];
    logic [63:0] rdata = '0;
    logic [63:0] last_wdata = '0;
    int unsigned wen_cnt = 0, ren_cnt = 0;
    logic        both_seen = 1'b0;

    always @(posedge clk) begin
        if (wen_to_mem) begin
            mem[addr_to_mem] <= data_to_mem;
            last_wdata       <= data_to_mem;
            wen_cnt          <= wen_cnt + 1;
        end
        if (ren_to_mem) begin
            rdata   <= mem[addr_to_mem];
            ren_cnt <= ren_cnt + 1;
        end
        if (wen_to_mem && ren_to_mem) both_seen <= 1'b1;
    end
    assign data_from_mem = rdata;

    logic [16:0] exp_q [$];
    logic [15:0] cur_fib [$];
    int unsigned n_cmp = 0, n_err = 0, n_coords = 0;
    bit          rnd_ready = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic        prev_stall = 1'b0;
    logic [16:0] prev_blk = '0;

    always @(negedge clk) begin
        if (!rst_n || flush) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("blk_hold_valid", blk_out_valid, 1);
                check_eq("blk_hold_data", blk_out, prev_blk);
            end
            if (blk_out_valid && blk_out_ready) begin
                if (exp_q.size() == 0) check_eq("blk_extra_token", exp_q.size(), 1);
                else                   check_eq("blk_out", blk_out, exp_q.pop_front());
            end
            prev_stall = blk_out_valid && !blk_out_ready;
            prev_blk   = blk_out;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (rnd_ready) blk_out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input int unsigned n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [16:0] tok);
        int unsigned n = 0;
        wr_data_in       = tok;
        wr_data_in_valid = 1'b1;
        @(negedge clk);
        while (!wr_data_in_ready && n < 3000) begin @(negedge clk); n++; end
        check_eq("wr_ready", wr_data_in_ready, 1);
        @(posedge clk); #1;
        wr_data_in_valid = 1'b0;
        wr_data_in       = '0;
        if (!tok[16]) begin
            cur_fib.push_back(tok[15:0]);
            n_coords++;
        end else if (tok == DONE_TOKEN) begin
            exp_q.push_back(DONE_TOKEN);
        end else begin
            exp_q.push_back({1'b0, 16'(cur_fib.size())});
            foreach (cur_fib[i]) exp_q.push_back({1'b0, cur_fib[i]});
            cur_fib.delete();
        end
    endtask

    task automatic wait_drain(input string tag);
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < 3000) begin @(posedge clk); n++; end
        #1;
        check_eq(tag, exp_q.size(), 0);
        step(3);
    endtask

    int unsigned w0, r0, c0, flen;

    initial begin
        step(3);
        @(negedge clk);
        check_eq("rst_blk_valid", blk_out_valid, 0);
        check_eq("rst_blk_out", blk_out, 0);
        check_eq("rst_wen", wen_to_mem, 0);
        check_eq("rst_ren", ren_to_mem, 0);
        check_eq("rst_addr", addr_to_mem, 0);
        check_eq("rst_wdata", data_to_mem, 0);
        check_eq("rst_wr_ready", wr_data_in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tile_en = 1'b1;
        step(1);
        check_eq("idle_wr_ready", wr_data_in_ready, 1);

        // Short fiber with partial line, then DONE.
        blk_out_ready = 1'b1;
        w0 = wen_cnt;
        send(17'd1); send(17'd2); send(17'd3); send(STOP_BASE); send(DONE_TOKEN);
        wait_drain("drain_t1");
        check_eq("t1_wen_count", wen_cnt - w0, 1);
        check_eq("t1_wdata", last_wdata, 64'h0000_0003_0002_0001);

        // Fiber spanning two words.
        w0 = wen_cnt; r0 = ren_cnt;
        for (int i = 10; i <= 14; i++) send(17'(i));
        send(STOP_BASE);
        wait_drain("drain_t2");
        check_eq("t2_wen_count", wen_cnt - w0, 2);
        check_eq("t2_ren_count", ren_cnt - r0, 2);
        check_eq("t2_words_used", dut.words_used_q, 0);

        // Empty fibers never touch the SRAM read port.
        r0 = ren_cnt;
        send(STOP_BASE); send(STOP_BASE | 17'd3); send(DONE_TOKEN);
        wait_drain("drain_t3");
        check_eq("t3_ren_count", ren_cnt - r0, 0);

        // Random backpressure on the block stream.
        rnd_ready = 1'b1;
        for (int f = 0; f < 6; f++) begin
            flen = $urandom_range(0, 9);
            for (int unsigned k = 0; k < flen; k++) send({1'b0, 16'($urandom)});
            send(STOP_BASE | 17'(f));
        end
        send(DONE_TOKEN);
        wait_drain("drain_rand");
        rnd_ready = 1'b0;
        blk_out_ready = 1'b1;
        step(2);

        // Two-word capacity: writer stalls until the reader frees a word.
        flush = 1'b1; step(1); flush = 1'b0;
        buffet_capacity_log = 4'd1;
        blk_out_ready = 1'b0;
        c0 = n_coords;
        fork
            begin
                for (int f = 0; f < 3; f++) begin
                    for (int k = 0; k < 4; k++) send(17'(100 + 4*f + k));
                    send(STOP_BASE);
                end
                send(DONE_TOKEN);
            end
            begin
                step(40);
                check_eq("full_coords_taken", n_coords - c0, 8);
                check_eq("full_wr_ready", wr_data_in_ready, 0);
                blk_out_ready = 1'b1;
            end
        join
        wait_drain("drain_full");
        check_eq("full_words_used", dut.words_used_q, 0);
        buffet_capacity_log = 4'd9;

        // Flush with an output stalled and a fiber half-written.
        blk_out_ready = 1'b0;
        send(17'd1); send(17'd2); send(STOP_BASE);
        send(17'd5); send(17'd6);
        step(2);
        check_eq("pre_flush_valid", blk_out_valid, 1);
        flush = 1'b1;
        exp_q.delete();
        cur_fib.delete();
        step(1);
        flush = 1'b0;
        @(negedge clk);
        check_eq("flush_blk_valid", blk_out_valid, 0);
        check_eq("flush_wen", wen_to_mem, 0);
        check_eq("flush_ren", ren_to_mem, 0);
        check_eq("flush_wr_ready", wr_data_in_ready, 1);
        @(posedge clk); #1;
        blk_out_ready = 1'b1;
        send(17'd7); send(STOP_BASE); send(DONE_TOKEN);
        wait_drain("drain_flush");

        check_eq("wen_ren_exclusive", both_seen, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
